// File: rtl/datapath_pkg.sv
// Shared types for the sequenced single-bus datapath: opcodes, sequencer
// states and bus-source selects.
package datapath_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_MUL  = 3'd4,
    OP_MOVE = 3'd5,
    OP_LOAD = 3'd6,
    OP_NOP  = 3'd7
  } op_e;

  typedef enum logic [3:0] {
    IDLE, TA, TB, TC, TD, MV, LREQ, LWB, NOPS
  } state_e;

  typedef enum logic [2:0] {
    SRC_NONE, SRC_RB, SRC_RC, SRC_ZLO, SRC_ZHI, SRC_MDR
  } bus_src_e;

endpackage

// File: rtl/gp_regfile.sv
// General register file: one write port, a bus read port and a debug read port.
module gp_regfile #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 16,
  localparam int RI_W     = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              we,
  input  logic [RI_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RI_W-1:0]   raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic [RI_W-1:0]   dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  always_ff @(posedge clock) begin
    if (clear)   regs <= '0;
    else if (we) regs[waddr] <= wdata;
  end

  assign rdata    = regs[raddr];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus register datapath with a micro-step sequencer: one register
// transfer command per handshake, plus a memory-read handshake for loads.
module bus_datapath_seq
  import datapath_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 16,
  localparam int RI_W     = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [RI_W-1:0]   cmd_ra,
  input  logic [RI_W-1:0]   cmd_rb,
  input  logic [RI_W-1:0]   cmd_rc,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic              done,
  output logic [DATA_W-1:0] bus_out,
  input  logic [RI_W-1:0]   dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  state_e              state, state_nx;
  op_e                 op;
  logic [RI_W-1:0]     ra, rb, rc, rsel;
  logic [DATA_W-1:0]   y, hi, lo, mdr, bus, rd;
  logic [2*DATA_W-1:0] z, alu_z, y_ext, b_ext;
  bus_src_e            src;
  logic                we, last;

  gp_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
    .clock(clock), .clear(clear), .we(we), .waddr(ra), .wdata(bus),
    .raddr(rsel), .rdata(rd), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always_comb begin
    state_nx = state;
    src      = SRC_NONE;
    we       = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        case (op_e'(cmd_op))
          OP_MOVE: state_nx = MV;
          OP_LOAD: state_nx = LREQ;
          OP_NOP:  state_nx = NOPS;
          default: state_nx = TA;
        endcase
      end
      TA: begin src = SRC_RB; state_nx = TB; end
      TB: begin src = SRC_RC; state_nx = TC; end
      TC: begin
        src = SRC_ZLO;
        if (op == OP_MUL) state_nx = TD;
        else begin we = 1'b1; last = 1'b1; state_nx = IDLE; end
      end
      TD:   begin src = SRC_ZHI; last = 1'b1; state_nx = IDLE; end
      MV:   begin src = SRC_RB; we = 1'b1; last = 1'b1; state_nx = IDLE; end
      LREQ: if (mem_ack) state_nx = LWB;
      LWB:  begin src = SRC_MDR; we = 1'b1; last = 1'b1; state_nx = IDLE; end
      NOPS: begin last = 1'b1; state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
  end

  // Rc is only needed on the bus during TB; every other read uses Rb.
  assign rsel = (state == TB) ? rc : rb;

  always_comb begin
    bus = '0;
    case (src)
      SRC_RB, SRC_RC: bus = rd;
      SRC_ZLO:        bus = z[DATA_W-1:0];
      SRC_ZHI:        bus = z[2*DATA_W-1:DATA_W];
      SRC_MDR:        bus = mdr;
      default:        bus = '0;
    endcase
  end

  // Sign-extended operands: the low 2*DATA_W bits of the product are the signed result.
  assign y_ext = {{DATA_W{y[DATA_W-1]}}, y};
  assign b_ext = {{DATA_W{bus[DATA_W-1]}}, bus};

  always_comb begin
    alu_z = '0;
    case (op)
      OP_ADD:  alu_z = {{DATA_W{1'b0}}, y + bus};
      OP_SUB:  alu_z = {{DATA_W{1'b0}}, y - bus};
      OP_AND:  alu_z = {{DATA_W{1'b0}}, y & bus};
      OP_OR:   alu_z = {{DATA_W{1'b0}}, y | bus};
      OP_MUL:  alu_z = y_ext * b_ext;
      default: alu_z = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      op    <= OP_NOP;
      ra    <= '0;
      rb    <= '0;
      rc    <= '0;
      y     <= '0;
      z     <= '0;
      hi    <= '0;
      lo    <= '0;
      mdr   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= last;
      if (state == IDLE && cmd_valid) begin
        op <= op_e'(cmd_op);
        ra <= cmd_ra;
        rb <= cmd_rb;
        rc <= cmd_rc;
      end
      if (state == TA) y <= bus;
      if (state == TB) z <= alu_z;
      if (state == TC && op == OP_MUL) lo <= bus;
      if (state == TD) hi <= bus;
      if (state == LREQ && mem_ack) mdr <= mem_data;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign mem_req   = (state == LREQ);
  assign mem_addr  = mem_req ? rd : '0;
  assign bus_out   = bus;
  assign hi_out    = hi;
  assign lo_out    = lo;

endmodule
